// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: FSM states,
// source/destination counts and where the destination field sits in a word.
package arb_pkg;

    typedef enum logic [1:0] {
        RESET_ST = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam int NUM_SRC = 4;
    localparam int NUM_DST = 4;
    localparam int DEST_W  = 2;

    // Destination index occupies the two top bits of a word
    function automatic int dest_hi(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int dest_lo(input int data_w);
        return data_w - DEST_W;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way rotating priority search: starting at rr_ptr and
// wrapping 3->0, the first eligible source wins.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [1:0]         rr_ptr,
    output logic               valid,
    output logic [1:0]         grant
);

    // Walk offsets from farthest to nearest so the nearest eligible source is written last
    always_comb begin
        logic [1:0] idx;
        valid = 1'b0;
        grant = rr_ptr;
        idx   = rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (eligible[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter moving words from four show-ahead input FIFOs to four
// output FIFOs, routed by the destination field in each head word. Strobes are
// combinational from registered state and gated by enable.
// Optional feature macro: ARB_COUNT_EN adds per-destination 8-bit push counters cnt4..cnt7.
module arbitro_rr
    import arb_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int AF_DEPTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo0_out,
    input  logic [DATA_W-1:0] fifo1_out,
    input  logic [DATA_W-1:0] fifo2_out,
    input  logic [DATA_W-1:0] fifo3_out,
    input  logic              fifo0_empty,
    input  logic              fifo1_empty,
    input  logic              fifo2_empty,
    input  logic              fifo3_empty,
    input  logic              fifo4_almost_full,
    input  logic              fifo5_almost_full,
    input  logic              fifo6_almost_full,
    input  logic              fifo7_almost_full,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic              push4,
    output logic              push5,
    output logic              push6,
    output logic              push7,
    output logic [1:0]        demux0,
    output logic              idle
`ifdef ARB_COUNT_EN
    ,
    output logic [7:0]        cnt4,
    output logic [7:0]        cnt5,
    output logic [7:0]        cnt6,
    output logic [7:0]        cnt7
`endif
);

    localparam int DHI = dest_hi(DATA_W);
    localparam int DLO = dest_lo(DATA_W);
    // Downstream push slack is informational; nothing here depends on it
    localparam int unused_af_depth = AF_DEPTH;

    state_t state, state_nxt;
    logic [1:0] rr_ptr, last_sel;

    logic [NUM_SRC-1:0][DATA_W-1:0] head;
    logic [NUM_SRC-1:0][1:0]        dest;
    logic [NUM_SRC-1:0]             empty, eligible, pop_v;
    logic [NUM_DST-1:0]             afull, push_v;
    logic                           run, valid;
    logic [1:0]                     grant;

    assign head  = {fifo3_out, fifo2_out, fifo1_out, fifo0_out};
    assign empty = {fifo3_empty, fifo2_empty, fifo1_empty, fifo0_empty};
    assign afull = {fifo7_almost_full, fifo6_almost_full, fifo5_almost_full, fifo4_almost_full};

    // Only the destination field of each head word matters for routing
    logic unused_head_bits;
    assign unused_head_bits = ^{fifo0_out[DLO-1:0], fifo1_out[DLO-1:0],
                                fifo2_out[DLO-1:0], fifo3_out[DLO-1:0]};

    // Grants only while ACTIVE and enable is still high, so dropping enable cuts strobes at once
    assign run = (state == ACTIVE) && enable;

    // A source is eligible when it has data and its own destination can accept it
    always_comb begin
        dest     = '0;
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dest[i]     = head[i][DHI:DLO];
            eligible[i] = run && !empty[i] && !afull[dest[i]];
        end
    end

    rr_pick u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .valid    (valid),
        .grant    (grant)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RESET_ST;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RESET_ST: state_nxt = IDLE;
            IDLE:     if (enable)  state_nxt = ACTIVE;
            ACTIVE:   if (!enable) state_nxt = IDLE;
            default:  state_nxt = RESET_ST;
        endcase
    end

    // Outputs: one pop with its matching push, source select holds last grant when idle
    always_comb begin
        pop_v  = '0;
        push_v = '0;
        demux0 = last_sel;
        if (valid) begin
            pop_v  = NUM_SRC'(1) << grant;
            push_v = NUM_DST'(1) << dest[grant];
            demux0 = grant;
        end
        idle = (state != ACTIVE) || (&empty);
    end

    assign {pop3, pop2, pop1, pop0}     = pop_v;
    assign {push7, push6, push5, push4} = push_v;

    // Advance the round-robin pointer past the winner and remember the selection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= 2'd0;
            last_sel <= 2'd0;
        end else if (valid) begin
            rr_ptr   <= grant + 2'd1;
            last_sel <= grant;
        end
    end

`ifdef ARB_COUNT_EN
    logic [NUM_DST-1:0][7:0] cnt;

    // Per-destination forwarded-word counters, wrapping 255->0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_DST; i++)
                if (push_v[i]) cnt[i] <= cnt[i] + 8'd1;
        end
    end

    assign cnt4 = cnt[0];
    assign cnt5 = cnt[1];
    assign cnt6 = cnt[2];
    assign cnt7 = cnt[3];
`endif

endmodule
